// File: rtl/tx_frame_ctrl_pkg.sv
// tx_ctrl_pkg: shared constants and FSM state type for the TX frame controller.
package tx_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int LEN_W = 11;
  localparam int MAX_LEN = 1518;
  localparam int IFG_CYC = 12;
  localparam int MIN_LEN = 60;
  typedef enum logic [2:0] {IDLE, XFER, DRAIN, PAD, GAP} state_e;
endpackage

// File: rtl/tx_frame_ctrl_if.sv
// tx_frame_ctrl_if: descriptor, FIFO read and MAC stream signals of the TX frame controller.
interface tx_frame_ctrl_if #(parameter int DATA_W = 8, parameter int LEN_W = 11);
  logic              desc_valid;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_ready;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  modport master (
    input  desc_valid, desc_len, fifo_empty, fifo_data, tx_ready,
    output desc_ready, fifo_read, tx_data, tx_valid, tx_last
  );
  modport slave (
    output desc_valid, desc_len, fifo_empty, fifo_data, tx_ready,
    input  desc_ready, fifo_read, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/tx_frame_ctrl_skid2.sv
// tx_skid2: 2-entry skid buffer catching FIFO read data returned one cycle after each read.
module tx_skid2 #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   occ_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= din_i;
      wp_q <= wp_q ^ push_i;
      rp_q <= rp_q ^ pop_i;
      occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
    end
  end
  assign head_o = mem_q[rp_q];
  assign occ_o = occ_q;
endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: drains frame FIFO bytes to the TX MAC with tx_last framing and inter-frame gap.
// Optional short-frame zero padding to MIN_LEN is enabled by defining TX_FRAME_CTRL_PAD_EN.
module tx_frame_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int DATA_W  = tx_ctrl_pkg::DATA_W,
  parameter int LEN_W   = tx_ctrl_pkg::LEN_W,
  parameter int MAX_LEN = tx_ctrl_pkg::MAX_LEN,
  parameter int IFG_CYC = tx_ctrl_pkg::IFG_CYC,
  parameter int MIN_LEN = tx_ctrl_pkg::MIN_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  tx_frame_ctrl_if.master  bus,
  output logic             busy_o,
  output logic             drop_pulse_o,
  output logic [15:0]      frame_cnt_o
);
  localparam int GW = $clog2(IFG_CYC + 1);
  state_e            state_q;
  logic [LEN_W-1:0]  rd_left_q, tx_left_q;
  logic [GW-1:0]     gap_q;
  logic [15:0]       frame_cnt_q;
  logic              inflight_q, drop_q;
  logic [DATA_W-1:0] head;
  logic [1:0]        occ;
  logic              xfer, drain, in_pad, pad_pend, tx_valid, beat, pop, push, rd;
`ifdef TX_FRAME_CTRL_PAD_EN
  logic [LEN_W-1:0]  pad_q;
  assign in_pad = state_q == PAD;
  assign pad_pend = pad_q != '0;
`else
  assign in_pad = 1'b0;
  assign pad_pend = 1'b0;
`endif
  assign xfer = state_q == XFER;
  assign drain = state_q == DRAIN;
  assign tx_valid = (xfer && occ != 2'd0) || in_pad;
  assign beat = tx_valid && bus.tx_ready;
  assign pop = xfer && beat;
  // Drained bytes never enter the skid, so DRAIN only has to count returns.
  assign push = inflight_q && !drain;
  assign rd = (xfer || drain) && rd_left_q != '0 && !bus.fifo_empty &&
              (({1'b0, occ} + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign bus.fifo_read = rd;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data = (xfer && occ != 2'd0) ? head : '0;
  assign bus.tx_last = tx_valid && tx_left_q == LEN_W'(1) && !(xfer && pad_pend);
  assign bus.desc_ready = rst_n && state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign drop_pulse_o = drop_q;
  assign frame_cnt_o = frame_cnt_q;
  tx_skid2 #(.W(DATA_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .din_i(bus.fifo_data), .head_o(head), .occ_o(occ)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_left_q <= '0;
      tx_left_q <= '0;
      gap_q <= '0;
      frame_cnt_q <= '0;
      inflight_q <= 1'b0;
      drop_q <= 1'b0;
`ifdef TX_FRAME_CTRL_PAD_EN
      pad_q <= '0;
`endif
    end else begin
      inflight_q <= rd;
      drop_q <= 1'b0;
      if (rd) rd_left_q <= rd_left_q - 1'b1;
      case (state_q)
        IDLE: if (bus.desc_valid) begin
          rd_left_q <= bus.desc_len;
          tx_left_q <= bus.desc_len;
          gap_q <= '0;
`ifdef TX_FRAME_CTRL_PAD_EN
          pad_q <= (bus.desc_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) - bus.desc_len : '0;
`endif
          if (bus.desc_len > LEN_W'(MAX_LEN)) state_q <= DRAIN;
          else if (bus.desc_len != '0) state_q <= XFER;
        end
        XFER: if (beat) begin
          tx_left_q <= tx_left_q - 1'b1;
          if (tx_left_q == LEN_W'(1)) begin
`ifdef TX_FRAME_CTRL_PAD_EN
            if (pad_pend) begin
              state_q <= PAD;
              tx_left_q <= pad_q;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              state_q <= GAP;
            end
`else
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q <= GAP;
`endif
          end
        end
        DRAIN: if (inflight_q) begin
          tx_left_q <= tx_left_q - 1'b1;
          if (tx_left_q == LEN_W'(1)) begin
            drop_q <= 1'b1;
            state_q <= GAP;
          end
        end
`ifdef TX_FRAME_CTRL_PAD_EN
        PAD: if (beat) begin
          tx_left_q <= tx_left_q - 1'b1;
          if (tx_left_q == LEN_W'(1)) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q <= GAP;
          end
        end
`endif
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GW'(IFG_CYC - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
